// File: rtl/seq_stepper.sv
// ============================================================================
//  Module   : seq_stepper
//  Brief    : Snapshots a packed 16-entry permutation on load and streams the
//             4-bit indices one per valid/ready transfer. Supports one-shot
//             and looping playback, abort, and an end-of-sequence done pulse.
//  Options  : SEQ_STEPPER_PERM_CHECK_EN adds a one-cycle CHECK state that
//             verifies the snapshot is a true permutation of 0..15 and raises
//             a sticky perm_err otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_stepper #(
  parameter int ELEM_W = 4,
  parameter int N_ELEM = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ELEM_W*N_ELEM-1:0] seq_in,
  input  logic                     load,
  input  logic                     loop,
  input  logic                     abort,
  output logic [ELEM_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [3:0]               elem_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     perm_err
);

  localparam logic [3:0] c_LAST_IDX = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_STREAM = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ELEM_W*N_ELEM-1:0] r_shadow;
  logic [3:0]               r_idx;

  logic w_capture;
  logic w_idx_inc;
  logic w_idx_clr;
  logic w_xfer;

  assign w_xfer = out_valid && out_ready;

`ifdef SEQ_STEPPER_PERM_CHECK_EN
  logic [N_ELEM-1:0] w_seen_mask;
  logic              w_perm_fail;
  logic              r_perm_err;

  // Seen mask: one bit per index value that appears anywhere in the snapshot.
  always_comb begin
    w_seen_mask = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      w_seen_mask[r_shadow[ELEM_W*i +: ELEM_W]] = 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
`ifdef SEQ_STEPPER_PERM_CHECK_EN
    w_perm_fail = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // abort has priority over a simultaneous load
        if (load && !abort) begin
          w_capture = 1'b1;
`ifdef SEQ_STEPPER_PERM_CHECK_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_STREAM;
`endif
        end
      end
`ifdef SEQ_STEPPER_PERM_CHECK_EN
      S_CHECK: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (&w_seen_mask) begin
          w_state_nxt = S_STREAM;
        end else begin
          w_perm_fail = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      S_STREAM: begin
        // abort wins; any concurrent bus transfer is simply not followed up
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_xfer) begin
          if (r_idx == c_LAST_IDX) begin
            if (loop) begin
              w_idx_clr = 1'b1;
            end else begin
              w_state_nxt = S_FIN;
            end
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Snapshot and element index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_idx    <= '0;
    end else begin
      if (w_capture) begin
        r_shadow <= seq_in;
        r_idx    <= '0;
      end else if (w_idx_clr) begin
        r_idx    <= '0;
      end else if (w_idx_inc) begin
        r_idx    <= r_idx + 4'd1;
      end
    end
  end

`ifdef SEQ_STEPPER_PERM_CHECK_EN
  // Sticky permutation error: cleared by an accepted load, set by a failed check.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perm_err <= 1'b0;
    end else if (w_capture) begin
      r_perm_err <= 1'b0;
    end else if (w_perm_fail) begin
      r_perm_err <= 1'b1;
    end
  end

  assign perm_err = r_perm_err;
`else
  assign perm_err = 1'b0;
`endif

  assign out_valid = (r_state == S_STREAM);
  assign out_data  = r_shadow[ELEM_W*r_idx +: ELEM_W];
  assign out_last  = out_valid && (r_idx == c_LAST_IDX);
  assign elem_idx  = r_idx;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_seq_stepper.sv
// ============================================================================
//  Module   : tb_seq_stepper
//  Brief    : Directed self-checking bench for seq_stepper.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_stepper;

  logic        clk;
  logic        rst_n;
  logic [63:0] seq_in;
  logic        load;
  logic        loop;
  logic        abort;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  elem_idx;
  logic        busy;
  logic        done;
  logic        perm_err;

  int tests;
  int fails;

  localparam logic [63:0] c_SEQ_A = 64'hFEDCBA9876543210;
  localparam logic [63:0] c_SEQ_B = 64'h2957AC0DF4E31B86;

  logic [3:0] exp_b [16] = '{4'h6, 4'h8, 4'hB, 4'h1, 4'h3, 4'hE, 4'h4, 4'hF,
                             4'hD, 4'h0, 4'hC, 4'hA, 4'h7, 4'h5, 4'h9, 4'h2};

  seq_stepper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_in    (seq_in),
    .load      (load),
    .loop      (loop),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .elem_idx  (elem_idx),
    .busy      (busy),
    .done      (done),
    .perm_err  (perm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse load for one rising edge; returns at the negedge after that edge.
  // With the permutation check built in, waits one further cycle so the
  // caller is always positioned where out_valid should first be high.
  task automatic do_load(input logic [63:0] s);
    @(negedge clk);
    seq_in = s;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
`ifdef SEQ_STEPPER_PERM_CHECK_EN
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL check_lat valid=%b want 0", out_valid); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; loop = 0; abort = 0; out_ready = 0; seq_in = c_SEQ_A;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", out_valid); end
    tests++; if (out_last  !== 1'b0) begin fails++; $display("FAIL rst_last got %b want 0", out_last); end
    tests++; if (busy      !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (done      !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
    tests++; if (perm_err  !== 1'b0) begin fails++; $display("FAIL rst_perm_err got %b want 0", perm_err); end
    tests++; if (elem_idx  !== 4'd0) begin fails++; $display("FAIL rst_idx got %0d want 0", elem_idx); end
    tests++; if (out_data  !== 4'd0) begin fails++; $display("FAIL rst_data got %0d want 0", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1; loop = 1'b0;
    do_load(c_SEQ_A);
    for (int k = 0; k < 16; k++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid k=%0d got %b want 1", k, out_valid); end
      tests++; if (out_data !== 4'(k)) begin fails++; $display("FAIL basic_data k=%0d got %0d want %0d", k, out_data, k); end
      tests++; if (out_last !== (k == 15)) begin fails++; $display("FAIL basic_last k=%0d got %b want %b", k, out_last, (k == 15)); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy k=%0d got %b want 1", k, busy); end
      @(negedge clk);
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL basic_done got %b want 1", done); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_fin_valid got %b want 0", out_valid); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int xfers, dones, stalled;
    logic [3:0] held_d, held_i;
    xfers = 0; dones = 0; stalled = 0; held_d = 0; held_i = 0;
    out_ready = 1'b0; loop = 1'b0;
    do_load(c_SEQ_B);
    for (int c = 0; c < 90; c++) begin
      out_ready = (c % 3 == 0);
      if (done) dones++;
      if (out_valid && stalled != 0) begin
        tests++; if (out_data !== held_d) begin fails++; $display("FAIL bp_hold_data got %0h want %0h", out_data, held_d); end
        tests++; if (elem_idx !== held_i) begin fails++; $display("FAIL bp_hold_idx got %0d want %0d", elem_idx, held_i); end
      end
      if (out_valid && out_ready) begin
        if (xfers < 16) begin
          tests++; if (out_data !== exp_b[xfers]) begin fails++; $display("FAIL bp_data n=%0d got %0h want %0h", xfers, out_data, exp_b[xfers]); end
          tests++; if (out_last !== (xfers == 15)) begin fails++; $display("FAIL bp_last n=%0d got %b want %b", xfers, out_last, (xfers == 15)); end
        end
        xfers++; stalled = 0;
      end else if (out_valid) begin
        stalled = 1; held_d = out_data; held_i = elem_idx;
      end
      @(negedge clk);
    end
    tests++; if (xfers !== 16) begin fails++; $display("FAIL bp_count got %0d want 16", xfers); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL bp_done_count got %0d want 1", dones); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_idle_busy got %b want 0", busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_loop();
    int xfers, dones;
    xfers = 0; dones = 0;
    out_ready = 1'b1; loop = 1'b1;
    do_load(c_SEQ_A);
    for (int c = 0; c < 50; c++) begin
      loop = (xfers < 16);
      if (done) dones++;
      if (xfers > 0 && xfers < 32) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL loop_bubble n=%0d got %b want 1", xfers, out_valid); end
      end
      if (out_valid && out_ready) begin
        tests++; if (out_data !== 4'(xfers % 16)) begin fails++; $display("FAIL loop_data n=%0d got %0d want %0d", xfers, out_data, xfers % 16); end
        xfers++;
      end
      @(negedge clk);
    end
    tests++; if (xfers !== 32) begin fails++; $display("FAIL loop_count got %0d want 32", xfers); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL loop_done_count got %0d want 1", dones); end
    loop = 1'b0;
  endtask

  task automatic test_abort();
    int c, seen;
    out_ready = 1'b1; loop = 1'b0;
    do_load(c_SEQ_A);
    c = 0;
    while (!(out_valid && elem_idx == 4'd5) && c < 30) begin @(negedge clk); c++; end
    tests++; if (c >= 30) begin fails++; $display("FAIL abort_reach idx=%0d want 5", elem_idx); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || out_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
  endtask

  task automatic test_ignored_load();
    int xfers, dones;
    xfers = 0; dones = 0;
    out_ready = 1'b1; loop = 1'b0;
    do_load(c_SEQ_A);
    for (int c = 0; c < 30; c++) begin
      if (done) dones++;
      if (out_valid) begin
        tests++; if (out_data !== 4'(xfers)) begin fails++; $display("FAIL ign_data n=%0d got %0d want %0d", xfers, out_data, xfers); end
        xfers++;
      end
      load   = (xfers == 3);
      seq_in = (xfers == 3) ? c_SEQ_B : c_SEQ_A;
      @(negedge clk);
    end
    load = 1'b0;
    tests++; if (xfers !== 16) begin fails++; $display("FAIL ign_count got %0d want 16", xfers); end
    tests++; if (dones !== 1) begin fails++; $display("FAIL ign_done_count got %0d want 1", dones); end
  endtask

  task automatic test_load_abort_idle();
    @(negedge clk);
    seq_in = c_SEQ_B; load = 1'b1; abort = 1'b1;
    @(negedge clk);
    load = 1'b0; abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL la_busy got %b want 0", busy); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL la_idle valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_midstream();
    int c;
    out_ready = 1'b1; loop = 1'b0;
    do_load(c_SEQ_A);
    c = 0;
    while (!(out_valid && elem_idx == 4'd9) && c < 30) begin @(negedge clk); c++; end
    tests++; if (c >= 30) begin fails++; $display("FAIL rstm_reach idx=%0d want 9", elem_idx); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstm_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstm_busy_done got %b%b want 00", busy, done); end
    tests++; if (elem_idx !== 4'd0) begin fails++; $display("FAIL rstm_idx got %0d want 0", elem_idx); end
    tests++; if (out_data !== 4'd0) begin fails++; $display("FAIL rstm_data got %0d want 0", out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rstm_last got %b want 0", out_last); end
    out_ready = 1'b0;
    do_load(c_SEQ_B);
    tests++; if (out_valid !== 1'b1 || out_data !== 4'h6 || elem_idx !== 4'd0) begin
      fails++; $display("FAIL rstm_restart valid=%b data=%0h idx=%0d want 1 6 0", out_valid, out_data, elem_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_perm_check();
`ifdef SEQ_STEPPER_PERM_CHECK_EN
    int seen;
    out_ready = 1'b1; loop = 1'b0;
    @(negedge clk);
    seq_in = 64'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL pc_check busy=%b valid=%b want 1 0", busy, out_valid); end
    @(negedge clk);
    tests++; if (perm_err !== 1'b1) begin fails++; $display("FAIL pc_err got %b want 1", perm_err); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid || done || busy) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL pc_quiet got %0d active cycles want 0", seen); end
    tests++; if (perm_err !== 1'b1) begin fails++; $display("FAIL pc_sticky got %b want 1", perm_err); end
    @(negedge clk);
    seq_in = c_SEQ_A; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    tests++; if (perm_err !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL pc_clear err=%b valid=%b want 0 0", perm_err, out_valid); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_data !== 4'd0) begin fails++; $display("FAIL pc_stream valid=%b data=%0d want 1 0", out_valid, out_data); end
    repeat (20) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL pc_end_busy got %b want 0", busy); end
`else
    out_ready = 1'b0; loop = 1'b0;
    do_load(64'h0);
    tests++; if (perm_err !== 1'b0) begin fails++; $display("FAIL pc_tied got %b want 0", perm_err); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pc_nocheck_valid got %b want 1", out_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b1;
`endif
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_loop();
    test_abort();
    test_ignored_load();
    test_load_abort_idle();
    test_reset_midstream();
    test_perm_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
